// File: rtl/startup_seq_pkg.sv
// Shared state definitions for the startup sequencer.
package startup_seq_pkg;

    localparam int unsigned STATE_W = 4;

    // One-hot encodings; state_o exposes these values directly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 4'b0001,
        ST_INIT = 4'b0010,
        ST_STRT = 4'b0100,
        ST_STOP = 4'b1000
    } state_t;

endpackage

// File: rtl/startup_seq_fsm_timer.sv
// Loadable down-counter used for the INIT and STOP dwell times.
module seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    // Clear beats load beats decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/startup_seq_fsm.sv
// Startup sequencer: IDLE -> INIT -> STRT -> STOP -> IDLE with abort and run counter.
module startup_seq_fsm
    import startup_seq_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned STOP_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               stop_i,
    output logic [STATE_W-1:0] state_o,
    output logic               busy_o,
    output logic               ready_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   run_cnt_o
);

    state_t             state_q;
    logic               tmr_clr;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_dec;
    logic [CNT_W-1:0]   tmr_value;
    logic               tmr_zero;

    seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clock_i),
        .rst_n    (reset_ni),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Timer control derived from the current state and this cycle's requests.
    always_comb begin
        tmr_clr      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        if (clear_i) begin
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(INIT_CYCLES - 1);
                    end
                end
                ST_INIT: tmr_dec = enable_i && !tmr_zero;
                ST_STRT: begin
                    if (stop_i) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(STOP_CYCLES - 1);
                    end
                end
                ST_STOP: tmr_dec = !tmr_zero;
                default: tmr_clr = 1'b1;
            endcase
        end
    end

    // State register plus flags computed from the next state so they line up with state_o.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            busy_o    <= 1'b0;
            ready_o   <= 1'b0;
            done_o    <= 1'b0;
            run_cnt_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (clear_i) begin
                state_q   <= ST_IDLE;
                busy_o    <= 1'b0;
                ready_o   <= 1'b0;
                run_cnt_o <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable_i) begin
                            state_q <= ST_INIT;
                            busy_o  <= 1'b1;
                        end
                    end
                    ST_INIT: begin
                        if (enable_i && tmr_zero) begin
                            state_q   <= ST_STRT;
                            busy_o    <= 1'b0;
                            ready_o   <= 1'b1;
                            run_cnt_o <= '0;
                        end
                    end
                    ST_STRT: begin
                        if (stop_i) begin
                            state_q <= ST_STOP;
                            busy_o  <= 1'b1;
                            ready_o <= 1'b0;
                        end else if (run_cnt_o != '1) begin
                            run_cnt_o <= run_cnt_o + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (tmr_zero) begin
                            state_q   <= ST_IDLE;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                            run_cnt_o <= '0;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        busy_o    <= 1'b0;
                        ready_o   <= 1'b0;
                        run_cnt_o <= '0;
                    end
                endcase
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_startup_seq_fsm.sv
// Directed bench for startup_seq_fsm with INIT_CYCLES=3, STOP_CYCLES=2, CNT_W=4.
module tb_startup_seq_fsm;
    import startup_seq_pkg::*;

    logic       clock_i = 1'b0;
    logic       reset_ni = 1'b1;
    logic       enable_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       stop_i = 1'b0;
    logic [3:0] state_o;
    logic       busy_o;
    logic       ready_o;
    logic       done_o;
    logic [3:0] run_cnt_o;

    int total = 0;
    int bad = 0;

    startup_seq_fsm #(
        .INIT_CYCLES (3),
        .STOP_CYCLES (2),
        .CNT_W       (4)
    ) dut (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .enable_i  (enable_i),
        .clear_i   (clear_i),
        .stop_i    (stop_i),
        .state_o   (state_o),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .run_cnt_o (run_cnt_o)
    );

    // Free-running clock, period 10.
    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_ni = 1'b0;
        #1;
        total++;
        if ({state_o, busy_o, ready_o, done_o, run_cnt_o} !== {4'b0001, 3'b000, 4'd0}) begin
            bad++;
            $display("FAIL reset_async got state=%b busy=%b ready=%b done=%b cnt=%0d exp 0001/0/0/0/0",
                     state_o, busy_o, ready_o, done_o, run_cnt_o);
        end
        step();
        step();
        reset_ni = 1'b1;
        step();
        total++;
        if ({state_o, busy_o, ready_o, done_o, run_cnt_o} !== {4'b0001, 3'b000, 4'd0}) begin
            bad++;
            $display("FAIL reset_release got state=%b busy=%b ready=%b done=%b cnt=%0d exp 0001/0/0/0/0",
                     state_o, busy_o, ready_o, done_o, run_cnt_o);
        end
    endtask

    task automatic test_start_run();
        int exp_cnt;
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({state_o, busy_o, ready_o} !== {4'b0010, 2'b10}) begin
                bad++;
                $display("FAIL init_seq[%0d] got state=%b busy=%b ready=%b exp 0010/1/0", i, state_o, busy_o, ready_o);
            end
        end
        step();
        enable_i = 1'b0;
        total++;
        if ({state_o, busy_o, ready_o, run_cnt_o} !== {4'b0100, 2'b01, 4'd0}) begin
            bad++;
            $display("FAIL strt_entry got state=%b busy=%b ready=%b cnt=%0d exp 0100/0/1/0", state_o, busy_o, ready_o, run_cnt_o);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_cnt = (k > 15) ? 15 : k;
            total++;
            if (state_o !== 4'b0100 || run_cnt_o !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL run_cnt[%0d] got state=%b cnt=%0d exp 0100/%0d", k, state_o, run_cnt_o, exp_cnt);
            end
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        total++;
        if ({state_o, busy_o, ready_o, done_o, run_cnt_o} !== {4'b1000, 3'b100, 4'd15}) begin
            bad++;
            $display("FAIL stop_entry got state=%b busy=%b ready=%b done=%b cnt=%0d exp 1000/1/0/0/15",
                     state_o, busy_o, ready_o, done_o, run_cnt_o);
        end
        step();
        total++;
        if (state_o !== 4'b1000 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL stop_second got state=%b done=%b exp 1000/0", state_o, done_o);
        end
        step();
        total++;
        if ({state_o, busy_o, ready_o, done_o, run_cnt_o} !== {4'b0001, 3'b001, 4'd0}) begin
            bad++;
            $display("FAIL stop_exit got state=%b busy=%b ready=%b done=%b cnt=%0d exp 0001/0/0/1/0",
                     state_o, busy_o, ready_o, done_o, run_cnt_o);
        end
        step();
        total++;
        if (state_o !== 4'b0001 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL done_one_shot got state=%b done=%b exp 0001/0", state_o, done_o);
        end
    endtask

    task automatic test_init_pause();
        logic [3:0] exp_tmr [5] = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd0};
        logic       en_seq  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            enable_i = en_seq[i];
            step();
            total++;
            if (state_o !== 4'b0010 || dut.u_timer.value !== exp_tmr[i]) begin
                bad++;
                $display("FAIL init_pause[%0d] got state=%b timer=%0d exp 0010/%0d", i, state_o, dut.u_timer.value, exp_tmr[i]);
            end
        end
        enable_i = en_seq[5];
        step();
        enable_i = 1'b0;
        total++;
        if (state_o !== 4'b0100 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL pause_to_strt got state=%b ready=%b exp 0100/1", state_o, ready_o);
        end
    endtask

    task automatic test_clear();
        step();
        step();
        total++;
        if (run_cnt_o !== 4'd2) begin
            bad++;
            $display("FAIL pre_clear_cnt got %0d exp 2", run_cnt_o);
        end
        clear_i = 1'b1;
        stop_i = 1'b1;
        step();
        clear_i = 1'b0;
        stop_i = 1'b0;
        total++;
        if ({state_o, busy_o, ready_o, done_o, run_cnt_o} !== {4'b0001, 3'b000, 4'd0}) begin
            bad++;
            $display("FAIL clear_beats_stop got state=%b busy=%b ready=%b done=%b cnt=%0d exp 0001/0/0/0/0",
                     state_o, busy_o, ready_o, done_o, run_cnt_o);
        end
        step();
        total++;
        if (state_o !== 4'b0001 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_no_done got state=%b done=%b exp 0001/0", state_o, done_o);
        end
        enable_i = 1'b1;
        step();
        step();
        total++;
        if (state_o !== 4'b0010 || dut.u_timer.value !== 4'd1) begin
            bad++;
            $display("FAIL pre_clear_init got state=%b timer=%0d exp 0010/1", state_o, dut.u_timer.value);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        enable_i = 1'b0;
        total++;
        if (state_o !== 4'b0001 || busy_o !== 1'b0 || dut.u_timer.value !== 4'd0) begin
            bad++;
            $display("FAIL clear_in_init got state=%b busy=%b timer=%0d exp 0001/0/0", state_o, busy_o, dut.u_timer.value);
        end
    endtask

    task automatic test_reset_in_stop();
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        enable_i = 1'b0;
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        total++;
        if (state_o !== 4'b1000) begin
            bad++;
            $display("FAIL reach_stop got state=%b exp 1000", state_o);
        end
        #1 reset_ni = 1'b0;
        #1;
        total++;
        if ({state_o, busy_o, ready_o, done_o, run_cnt_o} !== {4'b0001, 3'b000, 4'd0} || dut.u_timer.value !== 4'd0) begin
            bad++;
            $display("FAIL reset_in_stop got state=%b busy=%b ready=%b done=%b cnt=%0d timer=%0d exp 0001/0/0/0/0/0",
                     state_o, busy_o, ready_o, done_o, run_cnt_o, dut.u_timer.value);
        end
        #1 reset_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (state_o !== 4'b0001 || done_o !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle[%0d] got state=%b done=%b exp 0001/0", i, state_o, done_o);
            end
        end
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (state_o !== 4'b0010) begin
                bad++;
                $display("FAIL restart_init[%0d] got state=%b exp 0010", i, state_o);
            end
        end
        step();
        enable_i = 1'b0;
        total++;
        if (state_o !== 4'b0100 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL restart_strt got state=%b ready=%b exp 0100/1", state_o, ready_o);
        end
    endtask

    task automatic test_illegal_state();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        force dut.state_q = state_t'(4'b0110);
        #1 release dut.state_q;
        #1;
        total++;
        if (state_o !== 4'b0110) begin
            bad++;
            $display("FAIL forced_state got state=%b exp 0110", state_o);
        end
        step();
        total++;
        if (state_o !== 4'b0001 || busy_o !== 1'b0 || ready_o !== 1'b0 || dut.u_timer.value !== 4'd0) begin
            bad++;
            $display("FAIL illegal_recover got state=%b busy=%b ready=%b timer=%0d exp 0001/0/0/0",
                     state_o, busy_o, ready_o, dut.u_timer.value);
        end
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_init_pause();
        test_clear();
        test_reset_in_stop();
        test_illegal_state();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/startup_seq_fsm.md
STARTUP_SEQ_FSM -- requirements
Module: startup_seq_fsm

Interface
REQ-001 Parameter INIT_CYCLES, default 4, number of enabled cycles spent in INIT; legal range 1..2^CNT_W-1.
REQ-002 Parameter STOP_CYCLES, default 2, number of cycles spent in STOP before returning to IDLE; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 8, width of the internal timer and of run_cnt_o.
REQ-004 clock_i  input  1  single clock; all state changes occur on its rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 enable_i  input  1  advance request: IDLE->INIT and INIT progress.
REQ-007 clear_i  input  1  synchronous abort to IDLE from any state.
REQ-008 stop_i  input  1  request orderly shutdown from STRT.
REQ-009 state_o  output  4  one-hot state: IDLE=0001, INIT=0010, STRT=0100, STOP=1000.
REQ-010 busy_o  output  1  high in INIT or STOP.
REQ-011 ready_o  output  1  high in STRT.
REQ-012 done_o  output  1  one-cycle pulse on the STOP->IDLE transition.
REQ-013 run_cnt_o  output  CNT_W  cycles spent in current STRT visit, saturating.

Function
REQ-014 The block SHALL implement states IDLE, INIT, STRT, STOP, registered, one-hot encoded.
REQ-015 Priority per edge SHALL be: clear_i > stop_i > enable_i.
REQ-016 clear_i=1 SHALL force IDLE, timer=0, run_cnt_o=0 on the next edge, with no done_o pulse.
REQ-017 IDLE: enable_i=1 SHALL move to INIT and load the timer with INIT_CYCLES-1; otherwise IDLE holds.
REQ-018 INIT: enable_i=1 with timer>0 SHALL decrement the timer; enable_i=1 with timer==0 SHALL move to STRT.
REQ-019 INIT: enable_i=0 SHALL hold both state and timer (pause), so INIT lasts exactly INIT_CYCLES enabled cycles.
REQ-020 STRT: run_cnt_o SHALL be 0 on entry and increment each cycle in STRT, saturating at 2^CNT_W-1.
REQ-021 STRT: stop_i=1 SHALL move to STOP, load the timer with STOP_CYCLES-1, and freeze run_cnt_o.
REQ-022 stop_i SHALL be ignored in IDLE, INIT and STOP.
REQ-023 STOP SHALL decrement the timer each cycle regardless of enable_i; at timer==0 it SHALL move to IDLE and assert done_o for that one cycle.
REQ-024 run_cnt_o SHALL clear on entry to IDLE.
REQ-025 Any non-one-hot state value SHALL recover to IDLE on the next edge, with timer=0.
REQ-026 busy_o, ready_o and done_o SHALL be registered outputs, consistent with state_o in the same cycle.

Reset
REQ-027 reset_ni=0 SHALL immediately force state_o=0001, timer=0, run_cnt_o=0, busy_o=0, ready_o=0, done_o=0, independent of clock_i.
REQ-028 Reset asserted mid-INIT or mid-STOP SHALL abandon the sequence; after release the FSM SHALL start in IDLE with no done_o pulse.
REQ-029 Reset release SHALL take effect on the first rising edge of clock_i after reset_ni=1.

Structure
REQ-030 Package startup_seq_pkg SHALL hold the four state encodings and the state width constant (4).
REQ-031 The loadable down-counter SHALL be a sub-module, seq_timer (load, value, decrement, zero flag; width CNT_W).
REQ-032 The target size is 120-400 RTL lines, with no other sub-modules.

Verification (INIT_CYCLES=3, STOP_CYCLES=2, CNT_W=4)
REQ-033 Reset, then enable_i=1 held -> state_o: 0001 -> 0010 for 3 cycles -> 0100; ready_o=1 from that edge onward.
REQ-034 In INIT, drop enable_i for 2 cycles after the first INIT cycle -> INIT lasts 5 cycles total; timer holds at 1 during the pause.
REQ-035 In STRT for 20 cycles -> run_cnt_o rises 0..15 and holds at 15; stop_i=1 -> STOP for 2 cycles, then IDLE with done_o=1 for exactly one cycle, run_cnt_o=0.
REQ-036 clear_i and stop_i both 1 in STRT -> IDLE next edge, done_o stays 0; clear_i in INIT -> IDLE.
REQ-037 reset_ni pulsed low between clock edges in STOP -> outputs reset at once; done_o never pulses; a later enable_i restarts the full INIT sequence.
REQ-038 Force state to 0110 via the bench -> next edge state_o=0001.
